// File: rtl/drop_sequencer_if.sv
// rtl/drop_sequencer_if.sv - drop sequencer request/enable and actuator status bundle
//
// Purpose: groups the drop sequencer's control inputs and status outputs.
// Ports (as seen by the sequencer, i.e. the slave modport):
//   drop_req     in   qualified drop decision from the decision stage
//   drop_en      in   operator enable, must stay high while the hatch is open
//   clear_fault  in   one-cycle pulse releasing the fault state
//   hatch_open   out  actuator command
//   busy         out  high whenever the sequencer is not idle
//   fault        out  high while a fault is latched
//   drop_count   out  saturating count of completed drops
interface drop_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             drop_req;
  logic             drop_en;
  logic             clear_fault;
  logic             hatch_open;
  logic             busy;
  logic             fault;
  logic [CNT_W-1:0] drop_count;

  modport master (
    output drop_req, drop_en, clear_fault,
    input  hatch_open, busy, fault, drop_count
  );

  modport slave (
    input  drop_req, drop_en, clear_fault,
    output hatch_open, busy, fault, drop_count
  );
endinterface

// File: rtl/drop_sequencer.sv
// rtl/drop_sequencer.sv - qualified, timed hatch-open sequencer with drop counter
//
// Purpose: qualifies drop_req over STABLE_CYCLES consecutive samples, holds the
// hatch open for OPEN_CYCLES, cools down for COOLDOWN_CYCLES, counts completed
// drops (saturating) and latches a fault if drop_en falls while the hatch is open.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   bus   slave modport of drop_sequencer_if (drop_req, drop_en, clear_fault in;
//         hatch_open, busy, fault, drop_count out)
module drop_sequencer #(
  parameter int STABLE_CYCLES   = 16,
  parameter int OPEN_CYCLES     = 100,
  parameter int COOLDOWN_CYCLES = 50,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  drop_sequencer_if.slave  bus
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int OW = $clog2(OPEN_CYCLES + 1);
  localparam int DW = $clog2(COOLDOWN_CYCLES + 1);
  localparam int CW_SO = (SW > OW) ? SW : OW;
  localparam int CW = (CW_SO > DW) ? CW_SO : DW;

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] OPEN_LAST   = CW'(OPEN_CYCLES - 1);
  localparam logic [CW-1:0] COOL_LAST   = CW'(COOLDOWN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_OPEN,
    S_COOL,
    S_FAULT
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [CNT_W-1:0] count, count_next;
  logic             hatch_q, busy_q, fault_q;

  // Single shared counter: qualify count in ARM, timer in OPEN/COOL.
  // It is reloaded on every transition so it never carries across states.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    count_next = count;
    case (state)
      S_IDLE: begin
        if (bus.drop_req) begin
          if (STABLE_CYCLES == 1) begin
            state_next = S_OPEN;
            cnt_next   = '0;
          end else begin
            // This edge already counts as the first qualifying sample.
            state_next = S_ARM;
            cnt_next   = CW'(1);
          end
        end
      end
      S_ARM: begin
        if (!bus.drop_req) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_next = S_OPEN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_OPEN: begin
        // Losing the enable wins over normal completion on the same edge.
        if (!bus.drop_en) begin
          state_next = S_FAULT;
          cnt_next   = '0;
        end else if (cnt == OPEN_LAST) begin
          state_next = S_COOL;
          cnt_next   = '0;
          count_next = (count == '1) ? count : count + CNT_W'(1);
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_COOL: begin
        if (cnt == COOL_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_FAULT: begin
        if (bus.clear_fault) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are flopped from the next state so they line up with the state
  // register and never depend combinationally on inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      count   <= '0;
      hatch_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      count   <= count_next;
      hatch_q <= (state_next == S_OPEN);
      busy_q  <= (state_next != S_IDLE);
      fault_q <= (state_next == S_FAULT);
    end
  end

  assign bus.hatch_open = hatch_q;
  assign bus.busy       = busy_q;
  assign bus.fault      = fault_q;
  assign bus.drop_count = count;

endmodule

// File: tb/tb_drop_sequencer.sv
// tb/tb_drop_sequencer.sv - self-checking bench for drop_sequencer
module tb_drop_sequencer;

  localparam int STABLE = 4;
  localparam int OPENC  = 8;
  localparam int COOL   = 3;
  localparam int CNT_W  = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  drop_sequencer_if #(.CNT_W(CNT_W)) bus ();

  drop_sequencer #(
    .STABLE_CYCLES   (STABLE),
    .OPEN_CYCLES     (OPENC),
    .COOLDOWN_CYCLES (COOL),
    .CNT_W           (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining-cycle budgets and a run length of high samples.
  int m_run, m_open_left, m_cool_left, m_count;
  bit m_faulted;

  typedef struct {
    bit req;
    bit en;
    bit clr;
    bit hatch;
    bit busy;
    bit fault;
    int cnt;
  } vec_t;

  vec_t tv [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0;
    m_open_left = 0;
    m_cool_left = 0;
    m_count = 0;
    m_faulted = 0;
  endtask

  task automatic model_edge(input bit req, input bit en, input bit clr);
    if (m_faulted) begin
      if (clr) m_faulted = 0;
    end else if (m_open_left > 0) begin
      if (!en) begin
        m_faulted = 1;
        m_open_left = 0;
      end else begin
        m_open_left--;
        if (m_open_left == 0) begin
          if (m_count < CNT_MAX) m_count++;
          m_cool_left = COOL;
        end
      end
    end else if (m_cool_left > 0) begin
      m_cool_left--;
    end else if (req) begin
      m_run++;
      if (m_run == STABLE) begin
        m_run = 0;
        m_open_left = OPENC;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic compare_model();
    check("hatch_model", bus.hatch_open, 32'(m_open_left > 0));
    check("busy_model", bus.busy,
          32'(m_faulted || m_open_left > 0 || m_cool_left > 0 || m_run > 0));
    check("fault_model", bus.fault, 32'(m_faulted));
    check("count_model", bus.drop_count, 32'(m_count));
  endtask

  // Drive inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input bit req, input bit en, input bit clr);
    bus.drop_req    = req;
    bus.drop_en     = en;
    bus.clear_fault = clr;
    @(posedge clk);
    model_edge(req, en, clr);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.drop_req = 1'b0;
    bus.drop_en = 1'b1;
    bus.clear_fault = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    bus.drop_req = 1'b0;
    bus.drop_en = 1'b0;
    bus.clear_fault = 1'b0;
    model_reset();

    // Reset held: outputs stay cleared whatever the inputs do.
    for (int i = 0; i < 6; i++) begin
      bus.drop_req    = 1'($urandom_range(0, 1));
      bus.drop_en     = 1'($urandom_range(0, 1));
      bus.clear_fault = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("rst_hatch", bus.hatch_open, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_fault", bus.fault, 0);
      check("rst_count", bus.drop_count, 0);
    end
    rst = 1'b0;

    // Interrupted qualification: 1,1,1,0 then four highs.
    tv[0] = '{1, 1, 0, 0, 1, 0, 0};
    tv[1] = '{1, 1, 0, 0, 1, 0, 0};
    tv[2] = '{1, 1, 0, 0, 1, 0, 0};
    tv[3] = '{0, 1, 0, 0, 0, 0, 0};
    tv[4] = '{1, 1, 0, 0, 1, 0, 0};
    tv[5] = '{1, 1, 0, 0, 1, 0, 0};
    tv[6] = '{1, 1, 0, 0, 1, 0, 0};
    tv[7] = '{1, 1, 0, 1, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      step(tv[i].req, tv[i].en, tv[i].clr);
      check($sformatf("tv%0d_hatch", i), bus.hatch_open, 32'(tv[i].hatch));
      check($sformatf("tv%0d_busy", i), bus.busy, 32'(tv[i].busy));
      check($sformatf("tv%0d_fault", i), bus.fault, 32'(tv[i].fault));
      check($sformatf("tv%0d_count", i), bus.drop_count, 32'(tv[i].cnt));
    end

    // One full drop with request held: open after edges 4..11, idle after 15.
    do_reset();
    for (int e = 1; e <= 15; e++) begin
      step(1, 1, 0);
      check($sformatf("drop_hatch_e%0d", e), bus.hatch_open, 32'(e >= 4 && e <= 11));
      check($sformatf("drop_busy_e%0d", e), bus.busy, 32'(e <= 14));
      check($sformatf("drop_count_e%0d", e), bus.drop_count, 32'(e >= 12));
    end

    // Enable withdrawn on the 5th open cycle, then cleared.
    do_reset();
    for (int e = 1; e <= 8; e++) step(1, 1, 0);
    check("pre_fault_hatch", bus.hatch_open, 1);
    step(1, 0, 0);
    check("fault_hatch", bus.hatch_open, 0);
    check("fault_flag", bus.fault, 1);
    check("fault_count", bus.drop_count, 0);
    for (int e = 0; e < 3; e++) begin
      step(1, 1, 0);
      check("fault_hold", bus.fault, 1);
    end
    step(0, 1, 1);
    check("clear_fault", bus.fault, 0);
    check("clear_busy", bus.busy, 0);

    // Four back-to-back drops: counter saturates at 3.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      for (int e = 0; e < 15; e++) step(1, 1, 0);
      check($sformatf("sat_count_%0d", k), bus.drop_count, 32'((k < CNT_MAX) ? k : CNT_MAX));
      check($sformatf("sat_busy_%0d", k), bus.busy, 0);
    end

    // Asynchronous reset in the middle of an open cycle.
    for (int e = 0; e < 6; e++) step(1, 1, 0);
    check("mid_open_hatch", bus.hatch_open, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_hatch", bus.hatch_open, 0);
    check("async_busy", bus.busy, 0);
    check("async_count", bus.drop_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(0, 1, 0);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_count", bus.drop_count, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 9) < 8),
           1'($urandom_range(0, 99) >= 3),
           1'($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
